// File: rtl/move_pkg.sv
// Shared types and key decoding for the 2048 move sequencer.
package move_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE    = 3'd1,
    SPAWN   = 3'd2,
    CHECK   = 3'd3,
    OVER    = 3'd4,
    NEWGAME = 3'd5
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_dir_t;

  // Direction keys only; space is decoded separately since it is not a move.
  function automatic key_dir_t map_key(input logic [7:0] code);
    key_dir_t r;
    r.valid = 1'b1;
    r.dir   = UP;
    case (code)
      KEY_W:   r.dir = UP;
      KEY_S:   r.dir = DOWN;
      KEY_A:   r.dir = LEFT;
      KEY_D:   r.dir = RIGHT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/move_fifo.sv
// Small FIFO of 2-bit move directions. A push while full is accepted
// only when a pop happens in the same cycle. Flush wins over push/pop.
module move_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][1:0] mem;
  logic [AW-1:0]         wp, rp;
  logic [AW:0]           cnt;
  logic                  do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge frame_clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/move_sequencer.sv
// Keycode -> one-shot 2048 move commands, queued and sequenced through
// the board datapath as move / spawn / check phases with req/ack.
module move_sequencer
  import move_pkg::*;
#(
  parameter int         QDEPTH  = 2,
  parameter logic [7:0] TIMEOUT = 8'd120,
  parameter int         CNT_W   = 16
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [7:0]       keycode,
  output logic             move_req,
  output logic [1:0]       move_dir,
  input  logic             move_ack,
  input  logic             move_changed,
  output logic             spawn_req,
  input  logic             spawn_ack,
  output logic             check_req,
  input  logic             check_ack,
  input  logic             chk_over,
  input  logic             chk_won,
  output logic             newgame_req,
  input  logic             newgame_ack,
  output logic             game_over,
  output logic             game_won,
  output logic             timeout_err,
  output logic             drop_err,
  output logic             busy,
  output logic [CNT_W-1:0] move_count
);

  state_t     state, state_nxt;
  logic [7:0] key_prev;
  logic [7:0] tmo_cnt;
  logic       pending;
  dir_t       dir_q;
  key_dir_t   kd;
  logic       new_key, dir_press, space_press, accept;
  logic       q_push, q_pop, q_flush, q_full, q_empty;
  logic [1:0] q_dout;
  logic       ack_here, timed, tmo_hit, tmo_fire;

  // Edge detect on the keycode so a held key produces one press.
  assign kd          = map_key(keycode);
  assign new_key     = (keycode != key_prev);
  assign dir_press   = kd.valid & new_key;
  assign space_press = (keycode == KEY_SPACE) & new_key;
  assign accept      = (state != OVER) && (state != NEWGAME);

  assign q_push  = dir_press & accept;
  assign q_pop   = (state == IDLE) & ~pending & ~q_empty;
  assign q_flush = ((state == CHECK) & check_ack & chk_over) |
                   ((state == NEWGAME) & newgame_ack);

  move_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .push      (q_push),
    .pop       (q_pop),
    .flush     (q_flush),
    .din       (kd.dir),
    .dout      (q_dout),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Select the ack that belongs to the current phase; others are ignored.
  always_comb begin
    ack_here = 1'b0;
    case (state)
      MOVE:    ack_here = move_ack;
      SPAWN:   ack_here = spawn_ack;
      CHECK:   ack_here = check_ack;
      NEWGAME: ack_here = newgame_ack;
      default: ack_here = 1'b0;
    endcase
  end

  // The entry cycle sees count 0, so the phase lasts TIMEOUT frames; an
  // ack in the last of those frames is still taken.
  assign timed    = state inside {MOVE, SPAWN, CHECK, NEWGAME};
  assign tmo_hit  = ((tmo_cnt + 8'd1) == TIMEOUT);
  assign tmo_fire = timed & tmo_hit & ~ack_here;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    if (tmo_fire) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (pending) state_nxt = NEWGAME;
                 else if (!q_empty) state_nxt = MOVE;
        MOVE:    if (move_ack) state_nxt = move_changed ? SPAWN : IDLE;
        SPAWN:   if (spawn_ack) state_nxt = CHECK;
        CHECK:   if (check_ack) state_nxt = chk_over ? OVER : IDLE;
        OVER:    if (space_press) state_nxt = NEWGAME;
        NEWGAME: if (newgame_ack) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Key history, phase timer, pending new game and latched direction.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      key_prev <= 8'd0;
      tmo_cnt  <= 8'd0;
      pending  <= 1'b0;
      dir_q    <= UP;
      drop_err <= 1'b0;
    end else begin
      key_prev <= keycode;
      if (state_nxt != state) tmo_cnt <= 8'd0;
      else if (timed)         tmo_cnt <= tmo_cnt + 8'd1;
      // Entering NEWGAME consumes the request, so a timed-out new game
      // does not retry forever.
      if (state_nxt == NEWGAME)      pending <= 1'b0;
      else if (space_press & accept) pending <= 1'b1;
      if (q_pop) dir_q <= dir_t'(q_dout);
      drop_err <= q_push & q_full & ~q_pop;
    end
  end

  // Sticky status and the effective-move counter.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      game_over   <= 1'b0;
      game_won    <= 1'b0;
      timeout_err <= 1'b0;
      move_count  <= '0;
    end else if ((state == NEWGAME) && newgame_ack) begin
      game_over   <= 1'b0;
      game_won    <= 1'b0;
      timeout_err <= 1'b0;
      move_count  <= '0;
    end else begin
      if (tmo_fire) timeout_err <= 1'b1;
      if ((state == MOVE) && move_ack && move_changed && (move_count != '1))
        move_count <= move_count + 1'b1;
      if ((state == CHECK) && check_ack) begin
        game_won <= game_won | chk_won;
        if (chk_over) game_over <= 1'b1;
      end
    end
  end

  assign move_req    = (state == MOVE);
  assign spawn_req   = (state == SPAWN);
  assign check_req   = (state == CHECK);
  assign newgame_req = (state == NEWGAME);
  assign busy        = (state != IDLE) && (state != OVER);
  assign move_dir    = dir_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed + randomized bench for move_sequencer. The bench plays the
// board: it answers reqs with acks after random delays and predicts
// move directions, move_count (saturating) and status flags per move.
module tb_move_sequencer;

  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          frame_clk = 1'b0;
  logic          Reset = 1'b1;
  logic [7:0]    keycode = 8'd0;
  logic          move_req, spawn_req, check_req, newgame_req;
  logic [1:0]    move_dir;
  logic          move_ack = 0, move_changed = 0, spawn_ack = 0;
  logic          check_ack = 0, chk_over = 0, chk_won = 0, newgame_ack = 0;
  logic          game_over, game_won, timeout_err, drop_err, busy;
  logic [CW-1:0] move_count;

  move_sequencer #(.QDEPTH(2), .TIMEOUT(8'd4), .CNT_W(CW)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .move_req(move_req), .move_dir(move_dir), .move_ack(move_ack),
    .move_changed(move_changed), .spawn_req(spawn_req), .spawn_ack(spawn_ack),
    .check_req(check_req), .check_ack(check_ack), .chk_over(chk_over),
    .chk_won(chk_won), .newgame_req(newgame_req), .newgame_ack(newgame_ack),
    .game_over(game_over), .game_won(game_won), .timeout_err(timeout_err),
    .drop_err(drop_err), .busy(busy), .move_count(move_count)
  );

  always #5 frame_clk = ~frame_clk;

  int n_vec = 0, n_err = 0;
  int n_mv = 0, n_sp = 0, n_ck = 0, n_drop = 0;
  logic mv_q = 0, sp_q = 0, ck_q = 0;

  // Count req rising edges and drop pulses mid-cycle.
  always @(negedge frame_clk) begin
    if (move_req && !mv_q) n_mv++;
    if (spawn_req && !sp_q) n_sp++;
    if (check_req && !ck_q) n_ck++;
    if (drop_err) n_drop++;
    mv_q = move_req; sp_q = spawn_req; ck_q = check_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge frame_clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic req_of(input int which);
    case (which)
      0: return move_req;
      1: return spawn_req;
      2: return check_req;
      default: return newgame_req;
    endcase
  endfunction

  task automatic press(input logic [7:0] code);
    keycode = code; step(); keycode = 8'd0;
  endtask

  // Wait (bounded) for a phase request, hold it dly frames, then pulse the ack.
  task automatic do_phase(input int which, input int dly, input logic chg,
                          input logic ov, input logic wn, output logic [1:0] dir_seen);
    int n = 0;
    while (req_of(which) !== 1'b1 && n < 30) begin step(); n++; end
    check($sformatf("req_seen_%0d", which), 32'(req_of(which)), 32'd1);
    dir_seen = move_dir;
    repeat (dly) step();
    case (which)
      0: begin move_ack = 1; move_changed = chg; end
      1: spawn_ack = 1;
      2: begin check_ack = 1; chk_over = ov; chk_won = wn; end
      default: newgame_ack = 1;
    endcase
    step();
    move_ack = 0; move_changed = 0; spawn_ack = 0;
    check_ack = 0; chk_over = 0; chk_won = 0; newgame_ack = 0;
  endtask

  logic [7:0] keys [4];
  logic [1:0] dseen;
  logic [7:0] junk;
  int exp_cnt, exp_won, m0, s0, c0, d0, n, d, dly;
  logic chg, wn;

  initial begin
    keys[0] = 8'h1A; keys[1] = 8'h16; keys[2] = 8'h04; keys[3] = 8'h07;
    exp_cnt = 0; exp_won = 0;

    // Reset state
    step(); step();
    check("rst_reqs", 32'({move_req, spawn_req, check_req, newgame_req}), 32'd0);
    check("rst_flags", 32'({game_over, game_won, timeout_err, drop_err, busy}), 32'd0);
    check("rst_count", 32'(move_count), 32'd0);
    check("rst_dir", 32'(move_dir), 32'd0);
    Reset = 1'b0;
    step();

    // Key hold: A held across a full move/spawn/check sequence
    m0 = n_mv; s0 = n_sp; c0 = n_ck;
    keycode = 8'h04;
    do_phase(0, 1, 1, 0, 0, dseen);
    check("hold_dir", 32'(dseen), 32'd2);
    exp_cnt++;
    do_phase(1, 0, 0, 0, 0, dseen);
    do_phase(2, 0, 0, 0, 0, dseen);
    repeat (10) step();
    keycode = 8'd0; step(); step();
    check("hold_moves", 32'(n_mv - m0), 32'd1);
    check("hold_spawns", 32'(n_sp - s0), 32'd1);
    check("hold_checks", 32'(n_ck - c0), 32'd1);
    check("hold_count", 32'(move_count), 32'(exp_cnt));

    // Queueing: A in flight, W and S queue, D dropped while full
    d0 = n_drop;
    press(8'h04); step();
    check("q_movereq", 32'(move_req), 32'd1);
    keycode = 8'h1A; step();
    keycode = 8'd0;  step();
    keycode = 8'h16; step();
    keycode = 8'd0; move_ack = 1; move_changed = 1; step();
    move_ack = 0; move_changed = 0; exp_cnt++;
    keycode = 8'h07; step();
    check("q_drop_pulse", 32'(drop_err), 32'd1);
    keycode = 8'd0; step();
    check("q_drop_once", 32'(drop_err), 32'd0);
    do_phase(1, 0, 0, 0, 0, dseen);
    do_phase(2, 0, 0, 0, 0, dseen);
    do_phase(0, 0, 0, 0, 0, dseen);
    check("q_first_dir", 32'(dseen), 32'd0);
    do_phase(0, 0, 0, 0, 0, dseen);
    check("q_second_dir", 32'(dseen), 32'd1);
    step(); step();
    check("q_drop_count", 32'(n_drop - d0), 32'd1);
    check("q_idle", 32'(busy), 32'd0);

    // No-change move: straight back to IDLE, no spawn
    s0 = n_sp;
    press(8'h07);
    do_phase(0, 2, 0, 0, 0, dseen);
    check("nc_dir", 32'(dseen), 32'd3);
    check("nc_idle", 32'({busy, move_req, spawn_req}), 32'd0);
    step(); step();
    check("nc_nospawn", 32'(n_sp - s0), 32'd0);
    check("nc_count", 32'(move_count), 32'(exp_cnt));

    // Timeout in SPAWN, then the queued move proceeds
    keycode = 8'h1A; step();
    keycode = 8'h16; step();
    keycode = 8'd0;
    do_phase(0, 0, 1, 0, 0, dseen);
    exp_cnt++;
    check("to_first_dir", 32'(dseen), 32'd0);
    n = 0;
    while (spawn_req && n < 20) begin n++; step(); end
    check("to_spawn_frames", 32'(n), 32'd4);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    do_phase(0, 1, 0, 0, 0, dseen);
    check("to_next_dir", 32'(dseen), 32'd1);
    check("to_count", 32'(move_count), 32'(exp_cnt));

    // Game over with win; keys ignored; space starts a new game
    press(8'h04);
    do_phase(0, 0, 1, 0, 0, dseen);
    exp_cnt++;
    do_phase(1, 1, 0, 0, 0, dseen);
    do_phase(2, 1, 0, 1, 1, dseen);
    check("go_flags", 32'({game_over, game_won, busy}), 32'b110);
    check("go_count", 32'(move_count), 32'(exp_cnt));
    m0 = n_mv;
    press(8'h1A); repeat (4) step();
    check("go_keys_ignored", 32'(n_mv - m0), 32'd0);
    press(8'h2C);
    do_phase(3, 1, 0, 0, 0, dseen);
    exp_cnt = 0;
    check("ng_clear", 32'({game_over, game_won, timeout_err, busy}), 32'd0);
    check("ng_count", 32'(move_count), 32'd0);

    // Randomized moves against the transaction-level model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        do junk = 8'($urandom);
        while (junk == 8'h1A || junk == 8'h16 || junk == 8'h04 ||
               junk == 8'h07 || junk == 8'h2C);
        m0 = n_mv;
        keycode = junk; repeat (3) step(); keycode = 8'd0; step(); step();
        check("rnd_junk_ignored", 32'(n_mv - m0), 32'd0);
      end
      d = $urandom_range(0, 3);
      chg = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 5) == 0);
      dly = $urandom_range(0, 2);
      press(keys[d]);
      do_phase(0, dly, chg, 0, 0, dseen);
      check("rnd_dir", 32'(dseen), 32'(d));
      if (chg) begin
        if (exp_cnt < CMAX) exp_cnt++;
        do_phase(1, $urandom_range(0, 2), 0, 0, 0, dseen);
        do_phase(2, $urandom_range(0, 2), 0, 0, wn, dseen);
        if (wn) exp_won = 1;
      end
      check("rnd_count", 32'(move_count), 32'(exp_cnt));
      check("rnd_won", 32'(game_won), 32'(exp_won));
      check("rnd_idle", 32'({busy, game_over, timeout_err}), 32'd0);
    end

    // Space during a move: new game follows once the move completes
    press(8'h04); step();
    keycode = 8'h2C; step(); keycode = 8'd0;
    do_phase(0, 0, 0, 0, 0, dseen);
    do_phase(3, 0, 0, 0, 0, dseen);
    exp_cnt = 0; exp_won = 0;
    check("pend_clear", 32'({game_won, busy}), 32'd0);
    check("pend_count", 32'(move_count), 32'd0);

    // Build up a count, then reset mid-move with an entry queued
    press(8'h07);
    do_phase(0, 0, 1, 0, 0, dseen);
    do_phase(1, 0, 0, 0, 0, dseen);
    do_phase(2, 0, 0, 0, 0, dseen);
    check("pre_rst_count", 32'(move_count), 32'd1);
    keycode = 8'h04; step();
    keycode = 8'h16; step();
    check("pre_rst_move", 32'(move_req), 32'd1);
    keycode = 8'd0; Reset = 1'b1;
    step();
    check("mid_rst_reqs", 32'({move_req, spawn_req, check_req, newgame_req, busy}), 32'd0);
    check("mid_rst_count", 32'(move_count), 32'd0);
    Reset = 1'b0;
    m0 = n_mv;
    repeat (8) step();
    check("post_rst_noreq", 32'(n_mv - m0), 32'd0);
    press(8'h1A);
    do_phase(0, 0, 0, 0, 0, dseen);
    check("post_rst_dir", 32'(dseen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
